// File: rtl/short_list_loader.sv
// Builds a fixed-length list of random words for merge_sort: the first WEIGHT
// words are forced even, the rest get bits[1:0]=01, then the sorter is kicked.
module short_list_loader #(
    parameter int INT_WIDTH   = 32,
    parameter int INDEX_WIDTH = 10,
    parameter int LIST_LEN    = 761,
    parameter int WEIGHT      = 286
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   rand_valid,
    input  logic [INT_WIDTH-1:0]   rand_data,
    output logic                   rand_ready,
    output logic                   wr_en,
    output logic [INDEX_WIDTH-1:0] wr_addr,
    output logic [INT_WIDTH-1:0]   data_out,
    output logic                   sort_start,
    input  logic                   sort_done,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             dbg_state
);

    // Handshake: a word moves from the random source when rand_valid && rand_ready
    // in the same cycle; rand_ready depends only on the state, never on rand_valid.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_KICK      = 3'd2,
        ST_WAIT_SORT = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [INDEX_WIDTH-1:0] r_count;
    logic                   r_sort_start;
    logic                   r_wr_en;
    logic [INDEX_WIDTH-1:0] r_wr_addr;
    logic [INT_WIDTH-1:0]   r_data;
    logic                   w_xfer;
    logic                   w_last;
    logic                   w_in_weight;
    logic                   w_accept_start;
    logic [INT_WIDTH-1:0]   w_word;

    assign w_xfer         = (r_state == ST_LOAD) && rand_valid;
    assign w_last         = (r_count == INDEX_WIDTH'(LIST_LEN - 1));
    assign w_in_weight    = (32'(r_count) < 32'(WEIGHT));
    assign w_accept_start = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    always_comb begin
        w_word = rand_data;
        if (w_in_weight) begin
            w_word[0] = 1'b0;
        end else begin
            w_word[1] = 1'b0;
            w_word[0] = 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (start) w_next = ST_LOAD;
            ST_LOAD:          if (w_xfer && w_last) w_next = ST_KICK;
            ST_KICK:          w_next = ST_WAIT_SORT;
            // sort_done seen in the sort_start cycle is stale from a previous sort
            ST_WAIT_SORT:     if (sort_done && !r_sort_start) w_next = ST_DONE;
            default:          w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_sort_start <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_data       <= '0;
        end else begin
            r_state      <= w_next;
            r_sort_start <= (r_state == ST_KICK);
            r_wr_en      <= w_xfer;
            if (w_accept_start) begin
                r_count <= '0;
            end else if (w_xfer && !w_last) begin
                r_count <= r_count + 1'b1;
            end
            if (w_xfer) begin
                r_wr_addr <= r_count;
                r_data    <= w_word;
            end
        end
    end

    assign rand_ready = (r_state == ST_LOAD);
    assign busy       = (r_state == ST_LOAD) || (r_state == ST_KICK) || (r_state == ST_WAIT_SORT);
    assign done       = (r_state == ST_DONE);
    assign sort_start = r_sort_start;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign data_out   = r_data;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_short_list_loader.sv
// Bench for short_list_loader with LIST_LEN=8: scoreboarded write stream,
// hand-timed sort handshake and reset cases, plus a WEIGHT=0 / WEIGHT=8 table.
module tb_short_list_loader;

    localparam int W = 36;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    // main instance: LIST_LEN=8, WEIGHT=3
    logic        start_a, valid_a, sort_done_a;
    logic [31:0] data_a;
    logic        rand_ready_a, wr_en_a, sort_start_a, busy_a, done_a;
    logic [3:0]  wr_addr_a;
    logic [31:0] data_out_a;
    logic [2:0]  dbg_a;

    // weight-boundary instances share their inputs
    logic        start_bc, valid_bc, sort_done_bc;
    logic [31:0] data_bc;
    logic        rr_b, we_b, ss_b, busy_b, done_b;
    logic        rr_c, we_c, ss_c, busy_c, done_c;
    logic [3:0]  addr_b, addr_c;
    logic [31:0] dout_b, dout_c;
    logic [2:0]  dbg_b, dbg_c;

    short_list_loader #(.INT_WIDTH(32), .INDEX_WIDTH(4), .LIST_LEN(8), .WEIGHT(3)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .rand_valid(valid_a), .rand_data(data_a),
        .rand_ready(rand_ready_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .data_out(data_out_a),
        .sort_start(sort_start_a), .sort_done(sort_done_a), .busy(busy_a), .done(done_a),
        .dbg_state(dbg_a)
    );

    short_list_loader #(.INT_WIDTH(32), .INDEX_WIDTH(4), .LIST_LEN(8), .WEIGHT(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_bc), .rand_valid(valid_bc), .rand_data(data_bc),
        .rand_ready(rr_b), .wr_en(we_b), .wr_addr(addr_b), .data_out(dout_b),
        .sort_start(ss_b), .sort_done(sort_done_bc), .busy(busy_b), .done(done_b),
        .dbg_state(dbg_b)
    );

    short_list_loader #(.INT_WIDTH(32), .INDEX_WIDTH(4), .LIST_LEN(8), .WEIGHT(8)) dut_c (
        .clk(clk), .rst(rst), .start(start_bc), .rand_valid(valid_bc), .rand_data(data_bc),
        .rand_ready(rr_c), .wr_en(we_c), .wr_addr(addr_c), .data_out(dout_c),
        .sort_start(ss_c), .sort_done(sort_done_bc), .busy(busy_c), .done(done_c),
        .dbg_state(dbg_c)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // scoreboard
    logic [W-1:0] exp_q[$];
    logic [31:0]  mem_img [8];
    int           pulses;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int idx, input logic [31:0] d, input int weight);
        if (idx < weight) return d - (d % 32'd2);
        return d - (d % 32'd4) + 32'd1;
    endfunction

    always @(negedge clk) begin
        if (sort_start_a) pulses++;
        if (wr_en_a) begin
            logic [W-1:0] e;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write actual=addr %0d data %h required=no write",
                         wr_addr_a, data_out_a);
            end else begin
                e = exp_q.pop_front();
                if ({wr_addr_a, data_out_a} !== e) begin
                    bad++;
                    $display("FAIL write actual=addr %0d data %h required=addr %0d data %h",
                             wr_addr_a, data_out_a, e[35:32], e[31:0]);
                end
            end
            if (wr_addr_a < 4'd8) mem_img[wr_addr_a[2:0]] = data_out_a;
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: valid always, 1: valid 1,0,0 repeating, 2: random valid
    task automatic run_list(input int mode, input bit inject_start,
                            input logic [31:0] fixed, input bit use_fixed);
        int k;
        int cyc;
        bit v;
        logic [31:0] sq[$];
        int n01;
        int nev;
        k = 0;
        cyc = 0;
        pulses = 0;
        foreach (mem_img[i]) mem_img[i] = 'x;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        while (k < 8 && cyc < 100) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 3 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            valid_a = v;
            data_a  = use_fixed ? fixed : $urandom;
            start_a = inject_start && (cyc == 4);
            @(negedge clk);
            check("rand_ready_load", {31'd0, rand_ready_a}, 32'd1);
            check("done_cleared", {31'd0, done_a}, 32'd0);
            if (v) begin
                exp_q.push_back({4'(k), model_word(k, data_a, 3)});
                k++;
            end
            cyc++;
            tick();
        end
        check("load_finished", k, 8);
        valid_a = 1'b0;
        start_a = 1'b0;
        // KICK cycle
        @(negedge clk);
        check("kick_rand_ready", {31'd0, rand_ready_a}, 32'd0);
        check("kick_sort_start", {31'd0, sort_start_a}, 32'd0);
        tick();
        sort_done_a = 1'b1;
        @(negedge clk);
        check("sort_start_pulse", {31'd0, sort_start_a}, 32'd1);
        check("writes_drained", exp_q.size(), 0);
        tick();
        sort_done_a = 1'b0;
        @(negedge clk);
        check("stale_done_ignored", {31'd0, done_a}, 32'd0);
        check("wait_busy", {31'd0, busy_a}, 32'd1);
        repeat (4) tick();
        sort_done_a = 1'b1;
        @(negedge clk);
        check("done_before_sort", {31'd0, done_a}, 32'd0);
        tick();
        sort_done_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("done_held", {31'd0, done_a}, 32'd1);
            check("done_not_busy", {31'd0, busy_a}, 32'd0);
            tick();
        end
        check("one_sort_start", pulses, 1);
        // what a sorter would leave behind: 3 entries in {00,10}, 5 equal to 01
        foreach (mem_img[i]) sq.push_back(mem_img[i]);
        sq.sort();
        n01 = 0;
        nev = 0;
        foreach (sq[i]) begin
            if (sq[i][1:0] == 2'b01) n01++;
            else if (sq[i][0] == 1'b0) nev++;
        end
        check("sorted_even_count", nev, 3);
        check("sorted_01_count", n01, 5);
    endtask

    typedef struct {
        logic [31:0] data;
        logic [31:0] exp_w0;
        logic [31:0] exp_w8;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{32'h0000_0002, 32'h0000_0001, 32'h0000_0002};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFE};
        vecs[2] = '{32'h1234_5678, 32'h1234_5679, 32'h1234_5678};
        vecs[3] = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0002};

        rst = 1'b1;
        {start_a, valid_a, sort_done_a, data_a} = '0;
        {start_bc, valid_bc, sort_done_bc, data_bc} = '0;
        pulses = 0;
        repeat (3) tick();
        start_a = 1'b1;
        @(negedge clk);
        check("rst_rand_ready", {31'd0, rand_ready_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_done", {31'd0, done_a}, 32'd0);
        check("rst_wr_en", {31'd0, wr_en_a}, 32'd0);
        tick();
        start_a = 1'b0;
        rst = 1'b0;
        tick();

        run_list(0, 1'b0, 32'hFFFF_FFFF, 1'b1);
        run_list(1, 1'b1, 32'h0, 1'b0);
        for (int r = 0; r < 4; r++) run_list(2, r[0], 32'h0, 1'b0);

        // reset after four transfers, concurrent with a fifth
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid_a = 1'b1;
            data_a  = $urandom;
            @(negedge clk);
            exp_q.push_back({4'(i), model_word(i, data_a, 3)});
            tick();
        end
        data_a = $urandom;
        rst = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        tick();
        rst = 1'b0;
        start_a = 1'b0;
        valid_a = 1'b0;
        @(negedge clk);
        check("mid_rst_rand_ready", {31'd0, rand_ready_a}, 32'd0);
        check("mid_rst_wr_en", {31'd0, wr_en_a}, 32'd0);
        check("mid_rst_sort_start", {31'd0, sort_start_a}, 32'd0);
        check("mid_rst_busy", {31'd0, busy_a}, 32'd0);
        check("mid_rst_done", {31'd0, done_a}, 32'd0);
        check("mid_rst_wr_addr", {28'd0, wr_addr_a}, 32'd0);
        check("mid_rst_data_out", data_out_a, 32'd0);
        check("mid_rst_drained", exp_q.size(), 0);
        tick();
        @(negedge clk);
        check("post_rst_idle_busy", {31'd0, busy_a}, 32'd0);
        tick();
        run_list(0, 1'b0, 32'h0, 1'b0);

        // WEIGHT=0 and WEIGHT=8 boundary table
        foreach (vecs[r]) begin
            int nb;
            int nc;
            int wait_cyc;
            nb = 0;
            nc = 0;
            data_bc  = vecs[r].data;
            valid_bc = 1'b1;
            start_bc = 1'b1;
            tick();
            start_bc = 1'b0;
            for (int c = 0; c < 14; c++) begin
                @(negedge clk);
                if (we_b) begin
                    check("w0_addr", {28'd0, addr_b}, nb);
                    check("w0_data", dout_b, vecs[r].exp_w0);
                    nb++;
                end
                if (we_c) begin
                    check("w8_addr", {28'd0, addr_c}, nc);
                    check("w8_data", dout_c, vecs[r].exp_w8);
                    nc++;
                end
                tick();
            end
            check("w0_write_count", nb, 8);
            check("w8_write_count", nc, 8);
            valid_bc = 1'b0;
            sort_done_bc = 1'b1;
            wait_cyc = 0;
            while (!(done_b && done_c) && wait_cyc < 10) begin
                tick();
                wait_cyc++;
            end
            sort_done_bc = 1'b0;
            check("bc_done", {30'd0, done_b, done_c}, 32'd3);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/short_list_loader.md
SHORT_LIST_LOADER -- requirements
Module: short_list_loader

Interface
REQ-001 SHALL have parameter INT_WIDTH, default 32: width of each list word.
REQ-002 SHALL have parameter INDEX_WIDTH, default 10: address width of the sorter memory.
REQ-003 SHALL have parameter LIST_LEN, default 761: number of list words written per run.
REQ-004 SHALL have parameter WEIGHT, default 286: number of nonzero coefficients (t); legal range 0..LIST_LEN.
REQ-005 SHALL have clk  in  1: the single clock; all state changes on rising edge.
REQ-006 SHALL have rst  in  1: reset, synchronous and active-high.
REQ-007 SHALL have start  in  1: one-cycle request to build a new list.
REQ-008 SHALL have rand_valid  in  1: random source offers rand_data.
REQ-009 SHALL have rand_data  in  INT_WIDTH: random word.
REQ-010 SHALL have rand_ready  out  1: loader accepts rand_data this cycle.
REQ-011 SHALL have wr_en  out  1: write strobe to the merge_sort memory port.
REQ-012 SHALL have wr_addr  out  INDEX_WIDTH: write address to merge_sort.
REQ-013 SHALL have data_out  out  INT_WIDTH: write data to merge_sort.
REQ-014 SHALL have sort_start  out  1: one-cycle pulse starting merge_sort.
REQ-015 SHALL have sort_done  in  1: merge_sort done flag.
REQ-016 SHALL have busy  out  1: high in every state except IDLE and DONE.
REQ-017 SHALL have done  out  1: list loaded and sorted; held until next accepted start.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, KICK, WAIT_SORT, DONE.
REQ-019 IDLE/DONE: start=1 -> LOAD; count cleared to 0; done cleared the same edge.
REQ-020 start SHALL be ignored in LOAD, KICK, WAIT_SORT.
REQ-021 LOAD: rand_ready=1 (combinational on state); transfer occurs when rand_valid && rand_ready.
REQ-022 On a transfer with index i=count: word = rand_data with bit0 cleared if i<WEIGHT, else rand_data with bit1 cleared and bit0 set.
REQ-023 Write path registered: cycle after transfer, wr_en=1, wr_addr=i, data_out=word; wr_en=0 in cycles without a preceding transfer.
REQ-024 count increments by 1 per transfer; no increment when rand_valid=0 (stalls of any length allowed).
REQ-025 Transfer with i=LIST_LEN-1 -> KICK; rand_ready=0 from the next cycle; count never exceeds LIST_LEN-1.
REQ-026 KICK lasts one cycle (last write is on wr_en that cycle); next cycle state WAIT_SORT with sort_start=1 for exactly that one cycle.
REQ-027 WAIT_SORT: sort_done=1 sampled in any cycle after the sort_start cycle -> DONE, done=1 next cycle; a sort_done=1 in the sort_start cycle SHALL be ignored.
REQ-028 WEIGHT=0: every word gets bits[1:0]=01; WEIGHT=LIST_LEN: every word gets bit0=0.
REQ-029 Upper bits INT_WIDTH-1..2 SHALL pass through unmodified.

Reset
REQ-030 rst=1 SHALL force IDLE, count=0, and rand_ready, wr_en, sort_start, busy, done all 0; wr_addr and data_out 0.
REQ-031 rst SHALL take priority over start and over a concurrent transfer; a write pending from the reset cycle SHALL NOT be issued.
REQ-032 Reset mid-LOAD or mid-WAIT_SORT SHALL abandon the run; the next start rebuilds from index 0.

Verification
REQ-033 LIST_LEN=8, WEIGHT=3, rand_valid held 1, rand_data=32'hFFFFFFFF: start -> writes addr 0..7, data FFFFFFFE x3 then FFFFFFFD x5, consecutive cycles; sort_start pulses exactly once, 2 cycles after addr-7 write transfer.
REQ-034 Same params, rand_valid toggles 1,0,0,1,...: addresses strictly 0..7 with no gaps or duplicates, wr_en only after transfers, rand_ready 0 after 8th transfer.
REQ-035 sort_done asserted 5 cycles after sort_start -> done=1 next cycle, busy=0, done held until next start; start during LOAD ignored (no restart, count unchanged).
REQ-036 rst asserted after 4 transfers -> all outputs 0 next cycle, no further writes; subsequent start writes addr 0 first.
REQ-037 WEIGHT=0 and WEIGHT=8 with rand_data=32'h00000002: all words 00000001 and 00000002 respectively.
REQ-038 Integration with merge_sort (LIST_LEN=8): after done, sorted memory bits[1:0] give exactly 3 entries in {00,10} and 5 entries equal to 01.
